// File: rtl/prog_loader.sv
// Serial program loader: receives a sync/count/data/checksum frame and writes
// 16-bit words into the CPU instruction memory, releasing the CPU on success.
module prog_loader #(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int IW = ADDR_W + 1;
  localparam int CW = (IW > 8) ? IW : 9;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {IDLE, COUNT, DATA_HI, DATA_LO, CHECK, RUN} state_t;

  state_t         state, next_state;
  logic           ready_en;
  logic [IW-1:0]  idx, count, idx_next;
  logic [7:0]     csum, hi_byte, lo_byte;
  logic [TW-1:0]  tcnt;
  logic [CW-1:0]  rx_ext, max_words;
  logic           accept, active, timeout_hit, count_ok;

  assign rx_ready    = ready_en & ~imem_we;
  assign accept      = rx_valid & rx_ready;
  assign imem_addr   = idx[ADDR_W-1:0];
  assign imem_wdata  = {hi_byte, lo_byte};
  assign idx_next    = idx + IW'(1);
  assign rx_ext      = CW'(rx_data);
  assign max_words   = CW'(1) << ADDR_W;
  assign count_ok    = (rx_ext != '0) && (rx_ext <= max_words);
  assign active      = (state == COUNT) || (state == DATA_HI) ||
                       (state == DATA_LO) || (state == CHECK);
  assign timeout_hit = active && !accept && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // DATA_LO covers both the low-byte wait and the following write cycle;
  // the registered imem_we marks the write cycle and drives the exit.
  always_comb begin
    next_state = state;
    if (timeout_hit) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, RUN: if (accept && rx_data == SYNC) next_state = COUNT;
        COUNT:     if (accept) next_state = count_ok ? DATA_HI : IDLE;
        DATA_HI:   if (accept) next_state = DATA_LO;
        DATA_LO:   if (imem_we) next_state = (idx_next < count) ? DATA_HI : CHECK;
        CHECK:     if (accept) next_state = (rx_data == csum) ? RUN : IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
      imem_we  <= 1'b0;
      idx      <= '0;
      count    <= '0;
      csum     <= '0;
      hi_byte  <= '0;
      lo_byte  <= '0;
      tcnt     <= '0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      imem_we  <= 1'b0;
      if (accept || !active) tcnt <= '0;
      else                   tcnt <= tcnt + TW'(1);

      case (state)
        IDLE, RUN: begin
          if (accept && rx_data == SYNC) begin
            cpu_rst <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
          end
        end
        COUNT: begin
          if (accept) begin
            if (count_ok) begin
              count <= IW'(rx_ext);
              idx   <= '0;
              csum  <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_byte <= rx_data;
            csum    <= csum + rx_data;
          end
        end
        DATA_LO: begin
          if (accept) begin
            lo_byte <= rx_data;
            csum    <= csum + rx_data;
            imem_we <= 1'b1;
          end else if (imem_we) begin
            idx <= idx_next;
          end
        end
        CHECK: begin
          if (accept) begin
            if (rx_data == csum) begin
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (timeout_hit) begin
        err     <= 1'b1;
        cpu_rst <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, count limits, timeout,
// reload from RUN with a full 128-word frame, and reset mid-frame.
module tb_prog_loader;

  localparam int ADDR_W  = 7;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [15:0]       wq_data[$];
  logic              prev_we = 1'b0;
  int                we_long = 0;
  int                we_ready = 0;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write monitor sampled mid-cycle; also flags long pulses and ready during writes.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
      if (prev_we) we_long++;
      if (rx_ready) we_ready++;
    end
    prev_we <= imem_we;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drives one byte from a negedge and returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) check_eq("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    logic [7:0] sum;
    int bad;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

    // Reset values
    idle_cycles(3);
    check_eq("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("rst_imem_we", 32'(imem_we), 32'd0);
    check_eq("rst_addr_wdata", {9'd0, imem_addr, imem_wdata}, 32'd0);
    check_eq("rst_done_err", {30'd0, done, err}, 32'd0);
    rst = 1'b0;
    check_eq("ready_before_edge", 32'(rx_ready), 32'd0);
    @(negedge clk);
    check_eq("ready_after_edge", 32'(rx_ready), 32'd1);

    // Good load
    clear_log();
    send_byte(8'hA5);
    check_eq("sync_flags", {29'd0, cpu_rst, done, err}, 32'b100);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    check_eq("we_cycle_ready", {30'd0, imem_we, rx_ready}, 32'b10);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hBE);
    check_eq("good_flags", {29'd0, cpu_rst, done, err}, 32'b010);
    check_eq("good_nwrites", 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() == 2) begin
      check_eq("good_w0", {9'd0, wq_addr[0], wq_data[0]}, {9'd0, 7'd0, 16'h1234});
      check_eq("good_w1", {9'd0, wq_addr[1], wq_data[1]}, {9'd0, 7'd1, 16'hABCD});
    end

    // Reload from RUN with a bad checksum
    clear_log();
    send_byte(8'hA5);
    check_eq("reload_flags", {29'd0, cpu_rst, done, err}, 32'b100);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01); send_byte(8'hFF);
    check_eq("badsum_flags", {29'd0, cpu_rst, done, err}, 32'b101);
    check_eq("badsum_nwrites", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() == 1)
      check_eq("badsum_w0", {9'd0, wq_addr[0], wq_data[0]}, {9'd0, 7'd0, 16'h0001});
    send_byte(8'h3C);
    check_eq("err_sticky", {29'd0, cpu_rst, done, err}, 32'b101);

    // Count errors
    clear_log();
    send_byte(8'hA5);
    check_eq("sync_clears_err", 32'(err), 32'd0);
    send_byte(8'h00);
    check_eq("count0_err", 32'(err), 32'd1);
    send_byte(8'hA5); send_byte(8'h81);
    check_eq("count81_err", 32'(err), 32'd1);
    idle_cycles(2);
    check_eq("count_nwrites", 32'(wq_addr.size()), 32'd0);

    // Timeout
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    idle_cycles(TIMEOUT / 2);
    check_eq("timeout_early", 32'(err), 32'd0);
    idle_cycles(TIMEOUT);
    check_eq("timeout_flags", {29'd0, cpu_rst, done, err}, 32'b101);
    check_eq("timeout_nwrites", 32'(wq_addr.size()), 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h56); send_byte(8'h78); send_byte(8'hCE);
    check_eq("after_timeout_flags", {29'd0, cpu_rst, done, err}, 32'b010);
    check_eq("after_timeout_w", {9'd0, wq_addr[0], wq_data[0]}, {9'd0, 7'd0, 16'h5678});

    // Full 128-word frame from RUN
    clear_log();
    send_byte(8'hA5);
    check_eq("max_sync_flags", {29'd0, cpu_rst, done, err}, 32'b100);
    send_byte(8'h80);
    sum = 8'h00;
    for (int i = 0; i < 128; i++) begin
      send_byte(8'(i));
      send_byte(8'(i) ^ 8'h5A);
      sum = sum + 8'(i) + (8'(i) ^ 8'h5A);
    end
    check_eq("max_not_done_yet", 32'(done), 32'd0);
    send_byte(sum);
    check_eq("max_flags", {29'd0, cpu_rst, done, err}, 32'b010);
    check_eq("max_nwrites", 32'(wq_addr.size()), 32'd128);
    bad = 0;
    for (int i = 0; i < wq_addr.size(); i++)
      if (wq_addr[i] !== 7'(i) || wq_data[i] !== {8'(i), 8'(i) ^ 8'h5A}) bad++;
    check_eq("max_words_bad", 32'(bad), 32'd0);

    // Reset mid-frame
    clear_log();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
    rst = 1'b1;
    #1;
    check_eq("midrst_async", {29'd0, cpu_rst, rx_ready, imem_we}, 32'b100);
    @(negedge clk);
    check_eq("midrst_outs", {7'd0, imem_addr, imem_wdata, done, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    check_eq("garbage_flags", {29'd0, cpu_rst, done, err}, 32'b100);
    check_eq("garbage_nwrites", 32'(wq_addr.size()), 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h07); send_byte(8'h07);
    check_eq("post_rst_flags", {29'd0, cpu_rst, done, err}, 32'b010);
    check_eq("post_rst_nwrites", 32'(wq_addr.size()), 32'd1);

    check_eq("we_pulse_long", 32'(we_long), 32'd0);
    check_eq("we_with_ready", 32'(we_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, giving the instruction-memory word address width (128 words).
REQ-002 SHALL have parameter TIMEOUT, default 1000, giving the maximum clk cycles allowed between accepted bytes inside a frame.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx_data  input  8  incoming byte from the serial receiver.
REQ-006 SHALL have port rx_valid  input  1  rx_data holds a valid byte.
REQ-007 SHALL have port rx_ready  output  1  loader can accept a byte; a byte is accepted on a rising edge where rx_valid and rx_ready are both 1.
REQ-008 SHALL have port imem_we  output  1  write strobe to the CPU instruction memory.
REQ-009 SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port imem_wdata  output  16  instruction word to write.
REQ-011 SHALL have port cpu_rst  output  1  holds the processor in reset while 1.
REQ-012 SHALL have port done  output  1  a valid program is loaded and the CPU is released.
REQ-013 SHALL have port err  output  1  the last frame failed; sticky until the next sync byte is accepted.

Function
REQ-014 Frame format SHALL be: sync 0xA5, count byte N (1..2^ADDR_W words), then 2N data bytes (high byte first per word), then one checksum byte.
REQ-015 The checksum SHALL be the 8-bit modulo-256 sum of the 2N data bytes only (sync and count excluded).
REQ-016 The FSM SHALL have states IDLE, COUNT, DATA_HI, DATA_LO, CHECK and RUN.
REQ-017 IDLE and RUN SHALL go to COUNT on accepting 0xA5; all other bytes SHALL be discarded.
REQ-018 On the accepted sync byte, the next cycle SHALL have cpu_rst=1, done=0 and err=0.
REQ-019 COUNT SHALL take N=0 or N>2^ADDR_W to IDLE with err=1; otherwise it SHALL latch N, clear the word index and checksum, and go to DATA_HI.
REQ-020 DATA_HI SHALL latch the byte as the high byte, add it to the checksum, and go to DATA_LO.
REQ-021 DATA_LO SHALL add the byte to the checksum.
REQ-022 On the cycle after the DATA_LO byte is accepted, imem_we SHALL be 1 for exactly one cycle, with imem_addr = word index and imem_wdata = {high, low}.
REQ-023 After that write, the word index SHALL increment, and the FSM SHALL return to DATA_HI if index < N, else go to CHECK.
REQ-024 In CHECK, a checksum match SHALL go to RUN with cpu_rst=0 and done=1 from the next cycle.
REQ-025 In CHECK, a checksum mismatch SHALL go to IDLE with err=1 and cpu_rst=1.
REQ-026 Words already written by a failed frame SHALL remain in memory; the CPU stays held in reset.
REQ-027 Timeout: in COUNT, DATA_HI, DATA_LO and CHECK, a cycle counter SHALL clear on every accepted byte.
REQ-028 When the timeout counter reaches TIMEOUT, the FSM SHALL go to IDLE with err=1 and cpu_rst=1; the counter SHALL be inactive in IDLE and RUN.
REQ-029 rx_ready SHALL be 1 in every state except the single imem_we cycle, where it SHALL be 0.
REQ-030 imem_we SHALL never be asserted outside the cycle defined in REQ-022.
REQ-031 The word index SHALL be wide enough (ADDR_W+1 bits) to hold N=2^ADDR_W without wrap-around.
REQ-032 imem_addr SHALL use the low ADDR_W bits of the word index.

Reset
REQ-033 While rst=1, outputs SHALL be: state IDLE, cpu_rst=1, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err=0, counters and checksum 0.
REQ-034 rx_ready SHALL become 1 on the first clock edge after rst deasserts.
REQ-035 An rst asserted mid-frame SHALL abort the frame immediately with the REQ-033 values; no partial write SHALL be issued.

Verification
REQ-036 Good load: bytes A5 02 12 34 AB CD BE -> writes addr0=0x1234 and addr1=0xABCD, one imem_we pulse each; then done=1, cpu_rst=0, err=0.
REQ-037 Bad checksum: bytes A5 01 00 01 FF -> addr0=0x0001 is written; then err=1, done=0, cpu_rst=1, state IDLE.
REQ-038 Count errors: A5 00 gives err=1 with no writes; A5 81 (ADDR_W=7) also gives err=1 with no writes.
REQ-039 Timeout: A5 01 12, then idle for TIMEOUT cycles -> err=1, cpu_rst=1, no write; a following valid frame loads normally.
REQ-040 Reload from RUN: after a good load, sending A5 gives cpu_rst=1 and done=0 the next cycle; a max frame with N=0x80 writes addresses 0..127 in order and ends with done=1.
REQ-041 Reset mid-frame: rst pulsed after A5 02 12 -> all outputs return to REQ-033 values with no imem_we; garbage bytes sent before the next A5 are ignored.
